uart_tx_param: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8-bit, one-clock-per-bit serial transmitter.
- Accepts a parallel word on a valid/busy handshake and serialises it LSB-first as start bit, data, optional parity, and one or two stop bits.
- Each bit lasts a configurable number of clocks.
- Sits between the host-side register interface and the TX pad.
- Replaces the separate FSM, serializer, parity and mux instances with one self-contained block.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_bit_timer.sv | 25 ++
 rtl/uart_tx_param.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// Define UART_TX_PARITY_EN to build the optional parity stage.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period down-counter: load restarts a period, bit_end marks its last clock.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic en,
  input  logic load,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge gclk) begin
    if (!grst_n)                   cnt_q <= '0;
    else if (load)                 cnt_q <= RELOAD;
    else if (en && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign bit_end = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits.
// Parity stage present only when UART_TX_PARITY_EN is defined.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP_BITS,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
  logic [DATA_WIDTH-1:0] sh_data;
  logic                  sh_stop;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load, cap, bit_end;

`ifdef UART_TX_PARITY_EN
  logic sh_pe, sh_pt, par_bit;
  assign par_bit = (sh_pt == PAR_EVEN) ? ^sh_data : ~^sh_data;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  assign idx_nxt = idx_q + 1'b1;

  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .gclk    (CLK),
    .grst_n  (RST),
    .en      (state_q != IDLE),
    .load    (load),
    .bit_end (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sh_data <= '0;
      sh_stop <= STOP_ONE;
`ifdef UART_TX_PARITY_EN
      sh_pe   <= 1'b0;
      sh_pt   <= PAR_EVEN;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      // Frame is defined entirely by what was presented at the accept edge
      if (cap) begin
        sh_data <= P_DATA;
        sh_stop <= STOP_BITS;
`ifdef UART_TX_PARITY_EN
        sh_pe   <= PAR_EN;
        sh_pt   <= PAR_TYP;
`endif
      end
    end
  end

  // Outputs are computed one edge ahead so TX_OUT changes exactly on bit boundaries
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (DATA_VALID && !busy_q) begin
          cap     = 1'b1;
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: if (bit_end) begin
        load    = 1'b1;
        state_d = DATA;
        idx_d   = '0;
        tx_d    = sh_data[0];
      end
      DATA: if (bit_end) begin
        load = 1'b1;
        if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
          if (sh_pe) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else
`endif
          begin
            state_d = STOP;
            stop2_d = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          idx_d = idx_nxt;
          tx_d  = sh_data[idx_nxt];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        load    = 1'b1;
        state_d = STOP;
        stop2_d = 1'b0;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        if (sh_stop == STOP_TWO && !stop2_q) begin
          load    = 1'b1;
          stop2_d = 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Frame bit j of each expected entry is bits[j]; expectations are hand-computed.
module tb_uart_tx_param;

  localparam int C = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_EN, PAR_TYP, STOP_BITS;
  logic       TX_OUT, BUSY, DONE;

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          b2b;
    int          abort_t;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(C)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP_BITS  (STOP_BITS),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] bits, input int n, input bit b2b, input int abort_t);
    exp_t x;
    x.bits = bits; x.n = n; x.b2b = b2b; x.abort_t = abort_t;
    sb_q.push_back(x);
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && w < 200) begin @(negedge CLK); w++; end
    chk("idle_wait", 32'(w < 200), 1);
  endtask

  // Present one word for a single accept, then scramble inputs to prove shadowing
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic sb,
                      input logic [15:0] bits, input int n, input int abort_t);
    wait_idle();
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP_BITS = sb; DATA_VALID = 1'b1;
    push(bits, n, 1'b0, abort_t);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; STOP_BITS = ~sb;
  endtask

  initial begin : monitor
    exp_t e;
    bit   skip = 1'b0;
    bit   aborted;
    forever begin
      if (!skip) @(negedge CLK);
      skip = 1'b0;
      if (BUSY === 1'b1) begin
        chk("frame_expected", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() == 0) begin
          while (BUSY === 1'b1) @(negedge CLK);
        end else begin
          e = sb_q.pop_front();
          aborted = 1'b0;
          for (int t = 0; t < e.n * C; t++) begin
            if (t == e.abort_t) begin
              chk("abort_tx", TX_OUT, 1);
              chk("abort_busy", BUSY, 0);
              chk("abort_done", DONE, 0);
              @(negedge CLK);
              chk("abort_no_done", DONE, 0);
              aborted = 1'b1;
              break;
            end
            chk("tx_bit", TX_OUT, e.bits[t / C]);
            chk("busy_in_frame", BUSY, 1);
            chk("done_in_frame", DONE, 0);
            @(negedge CLK);
          end
          if (!aborted) begin
            chk("end_busy", BUSY, 0);
            chk("end_done", DONE, 1);
            chk("end_tx", TX_OUT, 1);
            @(negedge CLK);
            chk("done_1cyc", DONE, 0);
            if (e.b2b) chk("b2b_start", BUSY, 1);
            skip = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hA5;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP_BITS = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_tx", TX_OUT, 1);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
    end
    DATA_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_idle", BUSY, 0);

    // A5, no parity, one stop: 0 | 1,0,1,0,0,1,0,1 | 1
    send(8'hA5, 1'b0, 1'b0, 1'b0, 16'h034A, 10, -1);
    repeat (3) @(negedge CLK);
    P_DATA = 8'h00; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;

`ifdef UART_TX_PARITY_EN
    send(8'hA5, 1'b1, 1'b0, 1'b0, 16'h054A, 11, -1);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 16'h074A, 11, -1);
`else
    send(8'hA5, 1'b1, 1'b0, 1'b0, 16'h034A, 10, -1);
    send(8'hA5, 1'b1, 1'b1, 1'b0, 16'h034A, 10, -1);
`endif

    // 00 with two stop bits
    send(8'h00, 1'b0, 1'b0, 1'b1, 16'h0600, 11, -1);

    // Back-to-back: 3C then FF with DATA_VALID held
    wait_idle();
    P_DATA = 8'h3C; PAR_EN = 1'b0; STOP_BITS = 1'b0; DATA_VALID = 1'b1;
    push(16'h0278, 10, 1'b1, -1);
    push(16'h03FE, 10, 1'b0, -1);
    repeat (10) @(negedge CLK);
    P_DATA = 8'hFF;
    w = 0;
    while (DONE !== 1'b1 && w < 200) begin @(negedge CLK); w++; end
    chk("b2b_done_wait", 32'(w < 200), 1);
    @(negedge CLK);
    DATA_VALID = 1'b0;

    // Abort during data bit 3 (frame bit 4 starts at t = 4*C)
    send(8'hA5, 1'b0, 1'b0, 1'b0, 16'h034A, 10, 4 * C);
    repeat (15) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1'b0, 16'h0278, 10, -1);

    w = 0;
    while ((sb_q.size() != 0 || BUSY !== 1'b0) && w < 500) begin @(negedge CLK); w++; end
    repeat (3) @(negedge CLK);
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
